// File: rtl/adder_pkg.sv
// Shared sizing helpers for the pipelined adder: slice width and the
// legality check on the WIDTH/STAGES pair.
package adder_pkg;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Every stage must own a whole, non-empty slice of the operands.
  function automatic bit cfg_ok(input int width, input int stages);
    return (width >= 4) && (width <= 64) && (stages >= 1) &&
           (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One pipeline stage: adds its SLICE-bit operand slice with the incoming carry
// and forwards the operands plus the partially built sum to the next stage.
module adder_stage
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             valid_i,
  input  logic             carry_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] sum_i,
  output logic             valid_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] sum_o
);

  localparam int LO = IDX * SLICE;

  logic [SLICE:0]   slice_add;
  logic             msb_cin;
  logic [WIDTH-1:0] sum_d;

  logic             valid_q;
  logic             carry_q;
  logic             ovf_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  assign slice_add = {1'b0, a_i[LO +: SLICE]} + {1'b0, b_i[LO +: SLICE]} +
                     {{SLICE{1'b0}}, carry_i};

  // Carry into the slice MSB, recovered from the MSB sum bit.
  assign msb_cin = a_i[LO+SLICE-1] ^ b_i[LO+SLICE-1] ^ slice_add[SLICE-1];

  always_comb begin
    sum_d             = sum_i;
    sum_d[LO +: SLICE] = slice_add[SLICE-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
    end else if (en) begin
      valid_q <= valid_i;
      carry_q <= slice_add[SLICE];
      ovf_q   <= msb_cin ^ slice_add[SLICE];
      sum_q   <= sum_d;
    end
  end

  // Operand copies only matter while their valid bit is set, so no reset.
  always_ff @(posedge clk) begin
    if (en) begin
      a_q <= a_i;
      b_q <= b_i;
    end
  end

  assign valid_o = valid_q;
  assign carry_o = carry_q;
  assign ovf_o   = ovf_q;
  assign sum_o   = sum_q;
  assign a_o     = a_q;
  assign b_o     = b_q;

endmodule

// File: rtl/pipelined_adder.sv
// Carry-slice pipelined adder with valid/ready handshake; the whole pipeline
// advances together whenever the output register is free or being drained.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int SLICE = slice_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipelined_adder: WIDTH must be 4..64 and a multiple of STAGES");
  end

  logic                en;
  logic [STAGES-1:0]   valid_w;
  logic [STAGES-1:0]   carry_w;
  logic [STAGES-1:0]   ovf_w;
  logic [WIDTH-1:0]    a_w   [STAGES];
  logic [WIDTH-1:0]    b_w   [STAGES];
  logic [WIDTH-1:0]    sum_w [STAGES];
  logic                unused_tail;

  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      adder_stage #(
        .WIDTH (WIDTH),
        .SLICE (SLICE),
        .IDX   (k)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .valid_i (in_valid),
        .carry_i (cin),
        .a_i     (a),
        .b_i     (b),
        .sum_i   ({WIDTH{1'b0}}),
        .valid_o (valid_w[k]),
        .carry_o (carry_w[k]),
        .ovf_o   (ovf_w[k]),
        .a_o     (a_w[k]),
        .b_o     (b_w[k]),
        .sum_o   (sum_w[k])
      );
    end else begin : g_next
      adder_stage #(
        .WIDTH (WIDTH),
        .SLICE (SLICE),
        .IDX   (k)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .valid_i (valid_w[k-1]),
        .carry_i (carry_w[k-1]),
        .a_i     (a_w[k-1]),
        .b_i     (b_w[k-1]),
        .sum_i   (sum_w[k-1]),
        .valid_o (valid_w[k]),
        .carry_o (carry_w[k]),
        .ovf_o   (ovf_w[k]),
        .a_o     (a_w[k]),
        .b_o     (b_w[k]),
        .sum_o   (sum_w[k])
      );
    end
  end

  // Only the last stage's overflow is meaningful; its operand copies are dead.
  assign unused_tail = ^{a_w[STAGES-1], b_w[STAGES-1], ovf_w};

  assign out_valid = valid_w[STAGES-1];
  assign sum       = sum_w[STAGES-1];
  assign cout      = carry_w[STAGES-1];
  assign overflow  = ovf_w[STAGES-1];

endmodule
